// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/ALU-execute control unit for the 3-bus datapath.
// Moore strobes are decoded from the T-state (and the IR opcode in T3/T4).
module control_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int OP_W     = 5
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [31:0]     IR_in,
    input  logic            Mem_ready,
    input  logic            Stop,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Rout,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Rin,
    output logic            IncPC,
    output logic            Read,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic [OP_W-1:0] alu_op,
    output logic            Run,
    output logic            Illegal,
    output logic            Mem_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);

    typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    logic [OP_W-1:0] op;
    logic            op_alu, timeout, illegal_set, mem_err_set;
    logic            ir_unused;

    assign op        = IR_in[31 -: OP_W];
    // Register fields are decoded by the datapath's select/encode logic, not here.
    assign ir_unused = ^IR_in[31-OP_W:0];
    assign op_alu    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign timeout   = wait_cnt == CW'(WAIT_MAX - 1);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            Illegal  <= 1'b0;
            Mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == S_T1) ? wait_cnt + 1'b1 : '0;
            Illegal  <= Illegal | illegal_set;
            Mem_err  <= Mem_err | mem_err_set;
        end
    end

    always_comb begin
        state_nx    = S_T0;
        {PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin} = '0;
        {IRin, Yin, Rin, IncPC, Read, Gra, Grb, Grc, Run} = '0;
        alu_op      = '0;
        illegal_set = 1'b0;
        mem_err_set = 1'b0;
        case (state)
            S_T0: begin
                {PCout, MARin, IncPC, Zin, Run} = '1;
                state_nx = S_T1;
            end
            S_T1: begin
                {Zlowout, Read, MDRin, Run} = '1;
                PCin        = wait_cnt == '0;
                mem_err_set = !Mem_ready && timeout;
                state_nx    = Mem_ready ? S_T2 : timeout ? S_HALT : S_T1;
            end
            S_T2: begin
                {MDRout, IRin, Run} = '1;
                state_nx = S_T3;
            end
            S_T3: begin
                Run             = 1'b1;
                {Grb, Rout, Yin} = {3{op_alu}};
                illegal_set     = !op_alu && op != OP_NOP && op != OP_HALT;
                state_nx        = op_alu ? S_T4 : (op == OP_HALT || Stop) ? S_HALT : S_T0;
            end
            S_T4: begin
                {Grc, Rout, Zin, Run} = '1;
                alu_op   = op;
                state_nx = S_T5;
            end
            S_T5: begin
                {Zlowout, Gra, Rin, Run} = '1;
                state_nx = Stop ? S_HALT : S_T0;
            end
            S_HALT: state_nx = (!Stop && !Mem_err) ? S_T0 : S_HALT;
            default: state_nx = S_T0;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven check of the control sequencer strobes per T-state,
// plus hand sequences for memory timeout, sticky flags and asynchronous reset.
module tb_control_sequencer;
    logic        Clock = 1'b0, Reset_n = 1'b0, Mem_ready = 1'b0, Stop = 1'b0;
    logic [31:0] IR_in = '0;
    logic        PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
    logic        IncPC, Read, Gra, Grb, Grc, Run, Illegal, Mem_err;
    logic [4:0]  alu_op;
    logic [23:0] outv;
    int          tests = 0, fails = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR_in(IR_in), .Mem_ready(Mem_ready), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .alu_op(alu_op),
        .Run(Run), .Illegal(Illegal), .Mem_err(Mem_err)
    );

    assign outv = {PCout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
                   IncPC, Read, Gra, Grb, Grc, alu_op, Run, Illegal, Mem_err};

    localparam logic [23:0] PCOUT = 24'h1 << 23, ZLO = 24'h1 << 22, MDROUT = 24'h1 << 21;
    localparam logic [23:0] ROUT = 24'h1 << 20, MARIN = 24'h1 << 19, ZIN = 24'h1 << 18;
    localparam logic [23:0] PCIN = 24'h1 << 17, MDRIN = 24'h1 << 16, IRIN = 24'h1 << 15;
    localparam logic [23:0] YIN = 24'h1 << 14, RIN = 24'h1 << 13, INCPC = 24'h1 << 12;
    localparam logic [23:0] READ = 24'h1 << 11, GRA = 24'h1 << 10, GRB = 24'h1 << 9;
    localparam logic [23:0] GRC = 24'h1 << 8, RUN = 24'h4, ILL = 24'h2, MERR = 24'h1;

    localparam logic [23:0] E_T0  = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [23:0] E_T1F = ZLO | READ | MDRIN | PCIN | RUN;
    localparam logic [23:0] E_T1  = ZLO | READ | MDRIN | RUN;
    localparam logic [23:0] E_T2  = MDROUT | IRIN | RUN;
    localparam logic [23:0] E_T3A = GRB | ROUT | YIN | RUN;
    localparam logic [23:0] E_T3N = RUN;
    localparam logic [23:0] E_T5  = ZLO | GRA | RIN | RUN;
    localparam logic [23:0] E_OFF = 24'h0;

    localparam logic [31:0] I_AND = 32'h28918000, I_ADD = 32'h18000000, I_OR = 32'h30000000;
    localparam logic [31:0] I_NOP = 32'hD0000000, I_ILL = 32'hF8000000, I_HLT = 32'hD8000000;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic        stop;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] e_t4(input logic [4:0] op);
        return GRC | ROUT | ZIN | RUN | (24'(op) << 3);
    endfunction

    task automatic add(input logic [31:0] ir, input logic mr, input logic st, input logic [23:0] e);
        tbl.push_back('{ir, mr, st, e});
    endtask

    task automatic chk(input string name, input logic [23:0] exp);
        tests++;
        if (outv !== exp) begin
            fails++;
            $display("FAIL %s: outputs %h, expected %h", name, outv, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int  n;
        bit  done;
        // AND R1,R2,R3 with immediate memory
        add(I_AND, 1, 0, E_T0);      add(I_AND, 1, 0, E_T1F);     add(I_AND, 1, 0, E_T2);
        add(I_AND, 1, 0, E_T3A);     add(I_AND, 1, 0, e_t4(5));   add(I_AND, 1, 0, E_T5);
        // four-cycle T1, then NOP
        add(I_NOP, 0, 0, E_T0);      add(I_NOP, 0, 0, E_T1F);     add(I_NOP, 0, 0, E_T1);
        add(I_NOP, 0, 0, E_T1);      add(I_NOP, 1, 0, E_T1);      add(I_NOP, 1, 0, E_T2);
        add(I_NOP, 1, 0, E_T3N);
        // illegal opcode, then NOP leaves the flag alone
        add(I_ILL, 1, 0, E_T0);      add(I_ILL, 1, 0, E_T1F);     add(I_ILL, 1, 0, E_T2);
        add(I_ILL, 1, 0, E_T3N);     add(I_NOP, 1, 0, E_T0 | ILL); add(I_NOP, 1, 0, E_T1F | ILL);
        add(I_NOP, 1, 0, E_T2 | ILL); add(I_NOP, 1, 0, E_T3N | ILL);
        // ADD with Stop raised in T4 (ignored) and T5 (halts), then resume
        add(I_ADD, 1, 0, E_T0 | ILL); add(I_ADD, 1, 0, E_T1F | ILL); add(I_ADD, 1, 0, E_T2 | ILL);
        add(I_ADD, 1, 0, E_T3A | ILL); add(I_ADD, 1, 1, e_t4(3) | ILL); add(I_ADD, 1, 1, E_T5 | ILL);
        add(I_ADD, 1, 1, ILL);       add(I_ADD, 1, 0, ILL);
        // HALT opcode
        add(I_HLT, 1, 0, E_T0 | ILL); add(I_HLT, 1, 0, E_T1F | ILL); add(I_HLT, 1, 0, E_T2 | ILL);
        add(I_HLT, 1, 1, E_T3N | ILL); add(I_HLT, 1, 1, ILL);      add(I_HLT, 1, 0, ILL);
        // OR
        add(I_OR, 1, 0, E_T0 | ILL);  add(I_OR, 1, 0, E_T1F | ILL); add(I_OR, 1, 0, E_T2 | ILL);
        add(I_OR, 1, 0, E_T3A | ILL); add(I_OR, 1, 0, e_t4(6) | ILL); add(I_OR, 1, 0, E_T5 | ILL);
        add(I_OR, 1, 0, E_T0 | ILL);

        @(negedge Clock);
        #1 chk("reset", E_OFF);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        foreach (tbl[i]) begin
            IR_in     = tbl[i].ir;
            Mem_ready = tbl[i].mr;
            Stop      = tbl[i].stop;
            #1 chk($sformatf("vec%0d", i), tbl[i].exp);
            @(negedge Clock);
        end

        // memory timeout: sticky Mem_err, Stop cannot release, reset clears
        Reset_n = 1'b0;
        #1 chk("rst_clears_illegal", E_OFF);
        @(negedge Clock);
        Reset_n   = 1'b1;
        Mem_ready = 1'b0;
        Stop      = 1'b0;
        IR_in     = I_AND;
        @(negedge Clock);
        #1 chk("to_t0", E_T0);
        n    = 0;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge Clock);
            #1;
            if (!Run) done = 1;
            else if (Read) n++;
        end
        chk_int("t1_wait_cycles", n, 15);
        chk("merr_halt", MERR);
        for (int i = 0; i < 4; i++) begin
            Stop = i[0];
            @(negedge Clock);
            #1 chk($sformatf("merr_hold%0d", i), MERR);
        end
        Stop = 1'b0;
        Reset_n = 1'b0;
        #1 chk("merr_reset", E_OFF);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        #1 chk("merr_restart", E_T0);

        // asynchronous reset in the middle of T4
        Mem_ready = 1'b1;
        repeat (4) @(negedge Clock);
        #1 chk("pre_rst_t4", e_t4(5));
        #2 Reset_n = 1'b0;
        #1 chk("rst_async", E_OFF);
        @(negedge Clock);
        Reset_n = 1'b1;
        #1 chk("rst_state", E_OFF);
        @(negedge Clock);
        #1 chk("rst_then_t0", E_T0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
